// File: rtl/div_unit.sv
// Unsigned restoring divider: one quotient bit per cycle, MSB first.
// A division takes WIDTH iterations; Done pulses for one cycle with registered results.
module div_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             StartDiv,
  input  logic [WIDTH-1:0] Divident,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Done,
  output logic             Busy
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q, cnt_d;
  // Dividend bits shift out of the MSB while quotient bits shift in at the LSB.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] remo_q, remo_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic             last;
  logic             accept;

  // One extra bit keeps the carry when the divisor exceeds half the range.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign ge      = (shifted >= {1'b0, dvs_q});
  assign last    = (cnt_q == CntW'(WIDTH - 1));
  assign accept  = StartDiv && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    remo_d  = remo_q;

    unique case (state_q)
      S_IDLE: begin
        if (StartDiv) state_d = S_BUSY;
      end
      S_BUSY: begin
        rem_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], ge};
        cnt_d = cnt_q + CntW'(1);
        if (last) begin
          quo_d   = {dvd_q[WIDTH-2:0], ge};
          remo_d  = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = StartDiv ? S_BUSY : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      dvd_d = Divident;
      dvs_d = Divisor;
      rem_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
    end
  end

  assign Quotient  = quo_q;
  assign Remainder = remo_q;
  assign Done      = (state_q == S_DONE);
  assign Busy      = (state_q == S_BUSY);

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, results, ignored restarts,
// back-to-back requests and mid-division reset.
module tb_div_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        StartDiv = 1'b0;
  logic [15:0] Divident = '0;
  logic [15:0] Divisor = '0;
  logic [15:0] Quotient;
  logic [15:0] Remainder;
  logic        Done;
  logic        Busy;

  int n_checks = 0;
  int n_pass   = 0;

  div_unit #(.WIDTH(16)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .StartDiv (StartDiv),
    .Divident (Divident),
    .Divisor  (Divisor),
    .Quotient (Quotient),
    .Remainder(Remainder),
    .Done     (Done),
    .Busy     (Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Advance to the next cycle; sample point is 1 time unit after the edge.
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // Issue a request in the current cycle; returns in the following cycle.
  task automatic start(input logic [15:0] a, input logic [15:0] b);
    StartDiv = 1'b1;
    Divident = a;
    Divisor  = b;
    cyc();
    StartDiv = 1'b0;
    Divident = 16'($urandom);
    Divisor  = 16'($urandom);
  endtask

  // Called in cycle T+n0; waits (bounded) for Done and checks latency and results.
  task automatic wait_done(input string name, input int n0,
                           input logic [15:0] eq, input logic [15:0] er);
    int n = n0;
    int busy_cnt = 0;
    while (!Done && n < 40) begin
      busy_cnt += int'(Busy);
      cyc();
      n++;
    end
    check({name, " done_seen"}, int'(Done), 1);
    check({name, " latency"}, n, 17);
    check({name, " busy_cycles"}, busy_cnt, 17 - n0);
    check({name, " quotient"}, int'(Quotient), int'(eq));
    check({name, " remainder"}, int'(Remainder), int'(er));
  endtask

  vec_t vecs[$];

  initial begin
    logic [15:0] ra, rb, rq, rr;
    int seen_done;

    vecs.push_back('{16'd20000, 16'd10,    16'd2000,  16'd0});
    vecs.push_back('{16'd7,     16'd0,     16'hFFFF,  16'd7});
    vecs.push_back('{16'd65535, 16'd1,     16'd65535, 16'd0});
    vecs.push_back('{16'd5,     16'd9,     16'd0,     16'd5});
    vecs.push_back('{16'd65535, 16'd32769, 16'd1,     16'd32766});
    vecs.push_back('{16'd12345, 16'd123,   16'd100,   16'd45});
    vecs.push_back('{16'd40000, 16'd40001, 16'd0,     16'd40000});
    vecs.push_back('{16'd50000, 16'd33000, 16'd1,     16'd17000});
    vecs.push_back('{16'd65535, 16'd65535, 16'd1,     16'd0});
    vecs.push_back('{16'd32768, 16'd2,     16'd16384, 16'd0});
    vecs.push_back('{16'd1000,  16'd0,     16'hFFFF,  16'd1000});
    vecs.push_back('{16'd0,     16'd5,     16'd0,     16'd0});

    // Reset state, checked with no clock edge yet.
    #2;
    check("rst_quotient", int'(Quotient), 0);
    check("rst_remainder", int'(Remainder), 0);
    check("rst_done", int'(Done), 0);
    check("rst_busy", int'(Busy), 0);
    cyc();
    Reset = 1'b1;
    cyc();

    foreach (vecs[i]) begin
      start(vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i), 1, vecs[i].q, vecs[i].r);
      cyc();
      check($sformatf("vec%0d single_done", i), int'(Done), 0);
      check($sformatf("vec%0d idle", i), int'(Busy), 0);
    end

    // Restart while busy is ignored; then back-to-back request from the Done cycle.
    start(16'd100, 16'd7);
    repeat (4) cyc();
    StartDiv = 1'b1;
    Divident = 16'd9;
    Divisor  = 16'd3;
    cyc();
    StartDiv = 1'b0;
    wait_done("ignored_restart", 6, 16'd14, 16'd2);
    start(16'd9, 16'd3);
    wait_done("back_to_back", 1, 16'd3, 16'd0);
    cyc();
    check("b2b single_done", int'(Done), 0);

    // Mid-division reset aborts the request and clears results.
    start(16'd20000, 16'd10);
    repeat (7) cyc();
    Reset = 1'b0;
    #1;
    check("abort busy", int'(Busy), 0);
    check("abort done", int'(Done), 0);
    check("abort quotient", int'(Quotient), 0);
    check("abort remainder", int'(Remainder), 0);
    cyc();
    cyc();
    Reset = 1'b1;
    seen_done = 0;
    repeat (30) begin
      cyc();
      seen_done += int'(Done);
    end
    check("abort no_done", seen_done, 0);
    start(16'd50, 16'd6);
    wait_done("after_reset", 1, 16'd8, 16'd2);
    cyc();

    // Random operands against an integer reference.
    for (int k = 0; k < 150; k++) begin
      ra = 16'($urandom);
      rb = (k % 10 == 0) ? 16'd0 : 16'($urandom_range(1, (k % 2) ? 65535 : 300));
      rq = (rb == 0) ? 16'hFFFF : ra / rb;
      rr = (rb == 0) ? ra : ra % rb;
      start(ra, rb);
      wait_done($sformatf("rand%0d %0d/%0d", k, ra, rb), 1, rq, rr);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
